// File: rtl/dmem_bus_master.sv
// -----------------------------------------------------------------------------
// dmem_bus_master
//
// Memory-stage initiator for a Y86-64 core. It decodes one data-memory access
// from icode/valA/valE/valP and runs it as eight byte-wide req/ack transactions,
// lowest address first (little-endian quadword). When the access finishes it
// pulses done_o for one cycle. At the same moment it presents valm_o and
// dmem_error_o, and both hold their values until the next done.
//
// Ports
//   clk_i, rst_n_i      clock (rising edge), async active-low reset
//   start_i             launch an access; only looked at in IDLE
//   icode_i             instruction code (Y86 define.v encodings)
//   vala_i/vale_i/valp_i  operand values used for address and write data
//   bus_req_o           byte transaction request
//   bus_we_o            1 = write, 0 = read
//   bus_addr_o          byte address
//   bus_wdata_o         write byte
//   bus_ack_i           responder accepts / completes the current byte
//   bus_rdata_i         read byte, valid with bus_ack_i
//   valm_o              quadword read result
//   busy_o              access in progress (core stalls)
//   done_o              one-cycle completion pulse
//   dmem_error_o        illegal address or bus timeout for the last access
// -----------------------------------------------------------------------------
module dmem_bus_master #(
  parameter int ADDR_MAX = 1023,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [3:0]  icode_i,
  input  logic [63:0] vala_i,
  input  logic [63:0] vale_i,
  input  logic [63:0] valp_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [63:0] bus_addr_o,
  output logic [7:0]  bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [7:0]  bus_rdata_i,
  output logic [63:0] valm_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        dmem_error_o
);

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Highest legal base address of a quadword. The whole 8-byte span must
  // fit below ADDR_MAX. Comparing the base against this limit avoids the
  // wraparound that addr + 7 would suffer near the top of the 64-bit space.
  localparam logic [63:0] ADDR_LIMIT = 64'(ADDR_MAX) - 64'd7;

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q,  state_d;
  logic [2:0]        k_q,      k_d;
  logic [WAIT_W-1:0] wait_q,   wait_d;
  logic              we_q,     we_d;
  logic [63:0]       addr_q,   addr_d;
  logic [63:0]       wdata_q,  wdata_d;
  logic [63:0]       rbuf_q,   rbuf_d;
  logic [63:0]       valm_q,   valm_d;
  logic              err_q,    err_d;

  // Access decode, using the same rules as the memory stage.
  logic        dec_access;
  logic        dec_we;
  logic [63:0] dec_addr;
  logic [63:0] dec_data;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // that no path leaves it unassigned and no latch is inferred.
  always_comb begin
    dec_access = 1'b0;
    dec_we     = 1'b0;
    dec_addr   = vale_i;
    dec_data   = vala_i;
    unique case (icode_i)
      I_RMMOVQ: begin dec_access = 1'b1; dec_we = 1'b1; end
      I_MRMOVQ: begin dec_access = 1'b1; end
      I_CALL:   begin dec_access = 1'b1; dec_we = 1'b1; dec_data = valp_i; end
      I_RET:    begin dec_access = 1'b1; dec_addr = vala_i; end
      I_PUSHQ:  begin dec_access = 1'b1; dec_we = 1'b1; end
      I_POPQ:   begin dec_access = 1'b1; dec_addr = vala_i; end
      default:  ;
    endcase
  end

  // State register. The datapath registers are reset along with the control
  // state, so a reset in the middle of an access clears every output at once.
  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together on the edge, whatever order the statements are in.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      wait_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      valm_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wait_q  <= wait_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      valm_q  <= valm_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wait_d  = wait_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    valm_d  = valm_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (!dec_access) begin
            state_d = ST_DONE;
            valm_d  = '0;
            err_d   = 1'b0;
          end else if (dec_addr > ADDR_LIMIT) begin
            state_d = ST_DONE;
            valm_d  = '0;
            err_d   = 1'b1;
          end else begin
            state_d = ST_XFER;
            k_d     = '0;
            wait_d  = '0;
            we_d    = dec_we;
            addr_d  = dec_addr;
            wdata_d = dec_data;
            rbuf_d  = '0;
          end
        end
      end

      ST_XFER: begin
        if (bus_ack_i) begin
          wait_d = '0;
          if (!we_q) begin
            rbuf_d[{k_q, 3'b000} +: 8] = bus_rdata_i;
          end
          if (k_q == 3'd7) begin
            state_d = ST_DONE;
            err_d   = 1'b0;
            // valm is loaded only here, so it never shows a partial read.
            valm_d  = we_q ? 64'd0 : rbuf_d;
          end else begin
            k_d = k_q + 3'd1;
          end
        end else if (wait_q == WAIT_LAST) begin
          // This edge is wait cycle TIMEOUT for the current byte.
          state_d = ST_DONE;
          valm_d  = '0;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs. The bus fields are forced to zero outside XFER.
  always_comb begin
    bus_req_o    = 1'b0;
    bus_we_o     = 1'b0;
    bus_addr_o   = '0;
    bus_wdata_o  = '0;
    busy_o       = (state_q != ST_IDLE);
    done_o       = (state_q == ST_DONE);
    valm_o       = valm_q;
    dmem_error_o = err_q;
    if (state_q == ST_XFER) begin
      bus_req_o   = 1'b1;
      bus_we_o    = we_q;
      bus_addr_o  = addr_q + 64'(k_q);
      bus_wdata_o = wdata_q[{k_q, 3'b000} +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_bus_master.sv
// -----------------------------------------------------------------------------
// tb_dmem_bus_master
//
// Self-checking bench for dmem_bus_master. A byte-array responder answers bus
// requests after a configurable number of wait cycles (or never). The bench
// first applies a table of directed vectors with hand-derived expectations.
// It then runs a reset-in-flight sequence. Finally it applies random
// accesses, checked against a reference model working at the access level.
// -----------------------------------------------------------------------------
module tb_dmem_bus_master;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic [3:0]  icode_i;
  logic [63:0] vala_i, vale_i, valp_i;
  logic        bus_req_o, bus_we_o;
  logic [63:0] bus_addr_o;
  logic [7:0]  bus_wdata_o;
  logic        bus_ack_i;
  logic [7:0]  bus_rdata_i;
  logic [63:0] valm_o;
  logic        busy_o, done_o, dmem_error_o;

  dmem_bus_master #(.ADDR_MAX(1023), .TIMEOUT(255)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .icode_i      (icode_i),
    .vala_i       (vala_i),
    .vale_i       (vale_i),
    .valp_i       (valp_i),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_ack_i    (bus_ack_i),
    .bus_rdata_i  (bus_rdata_i),
    .valm_o       (valm_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .dmem_error_o (dmem_error_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:1023];

  typedef struct {
    logic [3:0]  ic;
    logic [63:0] a;
    logic [63:0] e;
    logic [63:0] p;
    int          gap;       // wait cycles before each ack; -1 = never ack
    bit          dup_start; // pulse start_i again during the transfer
    int          exp_lat;   // cycles from start edge to done_o
    logic        exp_err;
    logic [63:0] exp_valm;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Access-level reference: which operand supplies address and data.
  task automatic decode(input logic [3:0] ic, input logic [63:0] a, e, p,
                        output bit acc, output bit we,
                        output logic [63:0] addr, output logic [63:0] data);
    acc = 1'b1; we = 1'b0; addr = e; data = a;
    case (ic)
      4'h4: we = 1'b1;                   // rmmovq
      4'h5: ;                            // mrmovq
      4'h8: begin we = 1'b1; data = p; end // call
      4'h9: addr = a;                    // ret
      4'hA: we = 1'b1;                   // pushq
      4'hB: addr = a;                    // popq
      default: acc = 1'b0;
    endcase
  endtask

  function automatic logic [63:0] mem_quad(input logic [63:0] addr);
    logic [63:0] q = '0;
    for (int i = 7; i >= 0; i--) q = (q << 8) | 64'(mem[10'(addr + 64'(i))]);
    return q;
  endfunction

  // Expected outcome of an access, from the rules rather than the RTL.
  task automatic model(inout vec_t v);
    bit acc, we;
    logic [63:0] addr, data;
    decode(v.ic, v.a, v.e, v.p, acc, we, addr, data);
    v.exp_valm = '0;
    v.exp_err  = 1'b0;
    if (!acc) v.exp_lat = 1;
    else if (addr > 64'd1016) begin v.exp_lat = 1; v.exp_err = 1'b1; end
    else if (v.gap < 0) begin v.exp_lat = 256; v.exp_err = 1'b1; end
    else begin
      v.exp_lat = 8 * (v.gap + 1) + 1;
      if (!we) v.exp_valm = mem_quad(addr);
    end
  endtask

  // Launch one access, act as responder, and check the outcome.
  task automatic run_vec(input vec_t v, input string tag);
    bit acc, we, got_done;
    logic [63:0] addr, data, valm;
    logic err;
    int cyc, req_n, bidx, hold, seq_bad;
    decode(v.ic, v.a, v.e, v.p, acc, we, addr, data);
    icode_i = v.ic; vala_i = v.a; vale_i = v.e; valp_i = v.p;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    icode_i = 4'($urandom); vala_i = {$urandom, $urandom};
    vale_i = {$urandom, $urandom}; valp_i = {$urandom, $urandom};
    cyc = 1; req_n = 0; bidx = 0; hold = 0; seq_bad = 0; got_done = 0;
    valm = 'x; err = 1'bx;
    while (!got_done && cyc <= 400) begin
      if (done_o) begin
        got_done = 1;
        valm = valm_o;
        err  = dmem_error_o;
        if (bus_req_o || !busy_o) seq_bad++;
      end else begin
        if (!busy_o) seq_bad++;
        bus_ack_i = 1'b0;
        if (bus_req_o) begin
          req_n++;
          if (bus_addr_o !== addr + 64'(bidx) || bus_we_o !== we ||
              (we && bus_wdata_o !== data[8*bidx +: 8])) seq_bad++;
          if (v.gap >= 0 && hold == v.gap) begin
            bus_ack_i = 1'b1;
            if (we) mem[bus_addr_o[9:0]] = bus_wdata_o;
            else    bus_rdata_i = mem[bus_addr_o[9:0]];
            bidx++;
            hold = 0;
          end else begin
            bus_rdata_i = 8'($urandom);
            hold++;
          end
        end
        start_i = v.dup_start && (cyc == 3);
        if (start_i) begin icode_i = 4'h5; vale_i = 64'd8; end
        @(posedge clk_i); #1;
        cyc++;
      end
    end
    bus_ack_i = 1'b0;
    start_i   = 1'b0;
    check({tag, ".done_seen"}, 64'(got_done), 64'd1);
    check({tag, ".latency"}, 64'(cyc), 64'(v.exp_lat));
    check({tag, ".req_cycles"}, 64'(req_n), 64'(v.exp_lat - 1));
    check({tag, ".bus_seq_errs"}, 64'(seq_bad), 64'd0);
    check({tag, ".error"}, 64'(err), 64'(v.exp_err));
    check({tag, ".valm"}, valm, v.exp_valm);
    if (acc && we && !v.exp_err) check({tag, ".mem_written"}, mem_quad(addr), data);
    @(posedge clk_i); #1;
    check({tag, ".after_done_busy"}, {62'd0, done_o, busy_o}, 64'd0);
    check({tag, ".valm_held"}, valm_o, v.exp_valm);
    check({tag, ".error_held"}, 64'(dmem_error_o), 64'(v.exp_err));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [12];
    vec_t v;

    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      mem[16 + i]   = 8'h10 + 8'(i);
      mem[1016 + i] = 8'hA0 + 8'(i);
    end

    tbl[0]  = '{4'h5, 64'd0, 64'd16, 64'd0, 0, 0, 9, 1'b0, 64'h1716151413121110};
    tbl[1]  = '{4'hA, 64'h8877665544332211, 64'h100, 64'd0, 1, 0, 17, 1'b0, 64'd0};
    tbl[2]  = '{4'h6, 64'd16, 64'd16, 64'd0, 0, 0, 1, 1'b0, 64'd0};
    tbl[3]  = '{4'h4, 64'd5, 64'd1017, 64'd0, 0, 0, 1, 1'b1, 64'd0};
    tbl[4]  = '{4'hB, 64'd0, 64'd16, 64'd0, -1, 0, 256, 1'b1, 64'd0};
    tbl[5]  = '{4'h8, 64'd16, 64'h200, 64'h37, 0, 1, 9, 1'b0, 64'd0};
    tbl[6]  = '{4'h9, 64'd1016, 64'd16, 64'd0, 0, 0, 9, 1'b0, 64'hA7A6A5A4A3A2A1A0};
    tbl[7]  = '{4'h4, 64'hDEADBEEFCAFEF00D, 64'd1016, 64'd0, 0, 0, 9, 1'b0, 64'd0};
    tbl[8]  = '{4'h5, 64'd0, 64'd1016, 64'd0, 1, 0, 17, 1'b0, 64'hDEADBEEFCAFEF00D};
    tbl[9]  = '{4'h5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 0, 0, 1, 1'b1, 64'd0};
    tbl[10] = '{4'hC, 64'd16, 64'd16, 64'd16, 0, 0, 1, 1'b0, 64'd0};
    tbl[11] = '{4'h0, 64'd16, 64'd16, 64'd16, 0, 0, 1, 1'b0, 64'd0};

    rst_n_i = 1'b0; start_i = 1'b0; icode_i = 4'h5;
    vala_i = 64'd16; vale_i = 64'd16; valp_i = '0;
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    #12;
    check("reset.ctrl", {60'd0, bus_req_o, bus_we_o, busy_o, done_o}, 64'd0);
    check("reset.addr", bus_addr_o, 64'd0);
    check("reset.wdata", 64'(bus_wdata_o), 64'd0);
    check("reset.valm", valm_o, 64'd0);
    check("reset.error", 64'(dmem_error_o), 64'd0);
    #10 rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset while byte 3 of a read is on the bus; valm_o is nonzero beforehand.
    run_vec(tbl[0], "pre_reset");
    icode_i = 4'h5; vale_i = 64'd40; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int c = 1; c < 4; c++) begin
      bus_ack_i   = 1'b1;
      bus_rdata_i = mem[bus_addr_o[9:0]];
      @(posedge clk_i); #1;
    end
    check("midrst.byte3_addr", bus_addr_o, 64'd43);
    bus_ack_i = 1'b0;
    rst_n_i   = 1'b0;
    #1;
    check("midrst.req_busy_done", {61'd0, bus_req_o, busy_o, done_o}, 64'd0);
    check("midrst.valm", valm_o, 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    check("midrst.no_done", 64'(done_o), 64'd0);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    v = '{4'h5, 64'd0, 64'd40, 64'd0, 0, 0, 0, 1'b0, 64'd0};
    model(v);
    run_vec(v, "post_reset");

    // Random accesses against the reference model.
    for (int n = 0; n < 30; n++) begin
      v.ic = 4'($urandom);
      v.a  = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 1023));
      v.e  = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 1023));
      v.p  = {$urandom, $urandom};
      v.gap = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 2));
      v.dup_start = 1'($urandom);
      model(v);
      run_vec(v, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
